lsu_mem_adapter: RTL and testbench

- Load/store unit sitting directly upstream of the byte-addressed data memory.
- Converts core requests (RISC-V LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory accesses.
- Loads: extracts the addressed byte lane(s) and sign-/zero-extends them.
- Stores: SW writes directly; SB/SH use read-modify-write (RMW), because the memory write port always writes 4 bytes.
- Flags misaligned or unsupported requests without touching memory.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_byte_lane.sv | 81 ++++++++
 rtl/lsu_mem_adapter.sv | 147 ++++++++++++++
 tb/tb_lsu_mem_adapter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store adapter: RISC-V funct3 size codes
// and the adapter FSM state encoding.
package lsu_pkg;

  // funct3 size/sign codes for loads and stores
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RMW_RD = 3'd2;
  localparam logic [2:0] ST_WR     = 3'd3;
  localparam logic [2:0] ST_RESP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    LOAD   = ST_LOAD,
    RMW_RD = ST_RMW_RD,
    WR     = ST_WR,
    RESP   = ST_RESP
  } state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic for the load/store adapter.
// Ports:
//   we          1 = store, 0 = load (selects the illegal-funct3 set)
//   funct3      RISC-V size/sign code
//   a           byte offset within the word (addr[1:0])
//   word        memory word (read data)
//   wdata       store data, LSB-aligned
//   load_ext    addressed lane(s), sign- or zero-extended
//   store_merge word with the store lane(s) replaced by wdata
//   misaligned  half on odd byte, or word not on a word boundary
//   illegal     funct3 not a legal load/store code
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  a,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_ext,
  output logic [31:0] store_merge,
  output logic        misaligned,
  output logic        illegal
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (a)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = a[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    load_ext = '0;
    case (funct3)
      F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_ext = {24'd0, byte_sel};
      F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_ext = {16'd0, half_sel};
      F3_W:    load_ext = word;
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    store_merge = word;
    case (funct3)
      F3_B: begin
        case (a)
          2'd0:    store_merge = {word[31:8], wdata[7:0]};
          2'd1:    store_merge = {word[31:16], wdata[7:0], word[7:0]};
          2'd2:    store_merge = {word[31:24], wdata[7:0], word[15:0]};
          default: store_merge = {wdata[7:0], word[23:0]};
        endcase
      end
      F3_H:    store_merge = a[1] ? {wdata[15:0], word[15:0]} : {word[31:16], wdata[15:0]};
      F3_W:    store_merge = wdata;
      default: store_merge = word;
    endcase
  end

  always_comb begin
    // stores only have B/H/W; loads additionally have BU/HU
    if (we) illegal = (funct3 > F3_W);
    else    illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b01:   misaligned = a[0];
      2'b10:   misaligned = (a != 2'b00);
      default: misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_adapter.sv
// Load/store adapter between the core and a word-wide, byte-addressed data
// memory. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      core request handshake
//   req_we, req_funct3       store flag and RISC-V size/sign code
//   req_addr, req_wdata      byte address, LSB-aligned store data
//   rsp_valid                one-cycle response pulse
//   rsp_data, rsp_err        load result, error flag
//   mem_r_enb, mem_w_enb     memory read / write enables
//   mem_addr, mem_w_data     word address, full write word
//   mem_r_data               combinational memory read data
//
// state  | meaning
// IDLE   | ready for a request
// LOAD   | reading memory, registering the extracted load value
// RMW_RD | reading old word, registering the merged store word
// WR     | writing the full word
// RESP   | one-cycle response pulse
module lsu_mem_adapter
  import lsu_pkg::*;
#(
  parameter bit MISALIGN_ERR = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        mem_r_enb,
  output logic        mem_w_enb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_w_data,
  input  logic [31:0] mem_r_data
);

  state_t      state, state_nxt;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_word;

  logic        lane_we;
  logic [2:0]  lane_f3;
  logic [1:0]  lane_a;
  logic [31:0] load_ext, store_merge;
  logic        misaligned, illegal, req_err;
  logic [1:0]  a_acc;

  // In IDLE the lane decoder classifies the incoming request; afterwards it
  // works on the registered request, so mem_* never depend on req_*.
  assign lane_we = (state == IDLE) ? req_we : r_we;
  assign lane_f3 = (state == IDLE) ? req_funct3 : r_f3;
  assign lane_a  = (state == IDLE) ? req_addr[1:0] : r_addr[1:0];

  lsu_byte_lane u_lane (
    .we          (lane_we),
    .funct3      (lane_f3),
    .a           (lane_a),
    .word        (mem_r_data),
    .wdata       (r_word),
    .load_ext    (load_ext),
    .store_merge (store_merge),
    .misaligned  (misaligned),
    .illegal     (illegal)
  );

  assign req_err = illegal | (MISALIGN_ERR & misaligned);

  // With error reporting disabled, misaligned offsets snap to natural alignment.
  always_comb begin
    a_acc = req_addr[1:0];
    if (!MISALIGN_ERR) begin
      case (req_funct3[1:0])
        2'b01:   a_acc = {req_addr[1], 1'b0};
        2'b10:   a_acc = 2'b00;
        default: a_acc = req_addr[1:0];
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_err)                  state_nxt = RESP;
          else if (!req_we)             state_nxt = LOAD;
          else if (req_funct3 == F3_W)  state_nxt = WR;
          else                          state_nxt = RMW_RD;
        end
      end
      LOAD:    state_nxt = RESP;
      RMW_RD:  state_nxt = WR;
      WR:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      r_we     <= 1'b0;
      r_f3     <= '0;
      r_addr   <= '0;
      r_word   <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_f3     <= req_funct3;
            r_addr   <= {req_addr[31:2], a_acc};
            r_word   <= req_wdata;
            rsp_data <= '0;
            rsp_err  <= req_err;
          end
        end
        LOAD:   rsp_data <= load_ext;
        RMW_RD: r_word   <= store_merge;
        RESP: begin
          rsp_data <= '0;
          rsp_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE) & ~rst;
  assign rsp_valid  = (state == RESP) & ~rst;
  assign mem_r_enb  = (state == LOAD) | (state == RMW_RD);
  assign mem_w_enb  = (state == WR) & ~rst;
  assign mem_addr   = {r_addr[31:2], 2'b00};
  assign mem_w_data = (state == WR) ? r_word : '0;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
module tb_lsu_mem_adapter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_data;
  logic        mem_r_enb, mem_w_enb;
  logic [31:0] mem_addr, mem_w_data, mem_r_data;

  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  lsu_mem_adapter #(.MISALIGN_ERR(1'b1)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .mem_r_enb  (mem_r_enb),
    .mem_w_enb  (mem_w_enb),
    .mem_addr   (mem_addr),
    .mem_w_data (mem_w_data),
    .mem_r_data (mem_r_data)
  );

  // simple word memory, filled only through the adapter's own writes
  assign mem_r_data = mem[mem_addr[9:2]];
  always @(posedge clk) if (mem_w_enb) mem[mem_addr[9:2]] <= mem_w_data;

  // Drives one request and records when things happen, counting the
  // accepting cycle as cycle 0. Comparisons are made by the callers.
  task automatic run_req(input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int lat, output logic [31:0] data, output logic err,
                         output int w_cyc, output logic [31:0] w_addr,
                         output logic [31:0] w_data, output logic rd_seen);
    int n;
    lat = -1; data = '0; err = 1'b0; w_cyc = -1; w_addr = '0; w_data = '0; rd_seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (mem_r_enb) rd_seen = 1'b1;
      if (mem_w_enb) begin w_cyc = c; w_addr = mem_addr; w_data = mem_w_data; end
      if (rsp_valid) begin lat = c; data = rsp_data; err = rsp_err; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h40; req_wdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || mem_w_enb !== 1'b0 || rsp_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: ready=%b w_enb=%b rsp_valid=%b, required 0 0 0",
                 i, req_ready, mem_w_enb, rsp_valid);
      end
    end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b data=%h err=%b, required 0 00000000 0",
               rsp_valid, rsp_data, rsp_err);
    end
    checks++;
    if (mem_r_enb !== 1'b0 || mem_w_enb !== 1'b0 || mem_addr !== 32'h0 || mem_w_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: r=%b w=%b addr=%h wdata=%h, required 0 0 0 0",
               mem_r_enb, mem_w_enb, mem_addr, mem_w_data);
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_sw;
    int lat, wc; logic [31:0] d, wa, wdt; logic e, rd;
    run_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, lat, d, e, wc, wa, wdt, rd);
    checks++;
    if (wc !== 1 || wa !== 32'h20 || wdt !== 32'hDEAD_BEEF || rd !== 1'b0) begin
      errors++;
      $display("FAIL sw_write: cyc=%0d addr=%h data=%h rd=%b, required 1 00000020 deadbeef 0",
               wc, wa, wdt, rd);
    end
    checks++;
    if (lat !== 2 || e !== 1'b0 || d !== 32'h0) begin
      errors++;
      $display("FAIL sw_rsp: lat=%0d err=%b data=%h, required 2 0 00000000", lat, e, d);
    end
    // further words used by the load tests
    run_req(1'b1, 3'b010, 32'h10, 32'h8877_6655, lat, d, e, wc, wa, wdt, rd);
    run_req(1'b1, 3'b010, 32'h30, 32'h80F1_7F04, lat, d, e, wc, wa, wdt, rd);
    checks++;
    if (wc !== 1 || wa !== 32'h30 || lat !== 2) begin
      errors++;
      $display("FAIL sw_preload: cyc=%0d addr=%h lat=%0d, required 1 00000030 2", wc, wa, lat);
    end
    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, d, e, wc, wa, wdt, rd);
    checks++;
    if (d !== 32'hDEAD_BEEF || lat !== 2 || e !== 1'b0 || rd !== 1'b1) begin
      errors++;
      $display("FAIL lw_readback: data=%h lat=%0d err=%b rd=%b, required deadbeef 2 0 1",
               d, lat, e, rd);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  f3 [4]  = '{3'b000, 3'b100, 3'b101, 3'b001};
    logic [31:0] ad [4]  = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] ex [4]  = '{32'hFFFF_FF88, 32'h0000_0088, 32'h0000_8877, 32'h0000_6655};
    int lat, wc; logic [31:0] d, wa, wdt; logic e, rd;
    for (int i = 0; i < 4; i++) begin
      run_req(1'b0, f3[i], ad[i], 32'h0, lat, d, e, wc, wa, wdt, rd);
      checks++;
      if (d !== ex[i] || lat !== 2 || e !== 1'b0 || wc !== -1) begin
        errors++;
        $display("FAIL load%0d f3=%b addr=%h: data=%h lat=%0d err=%b wcyc=%0d, required %h 2 0 -1",
                 i, f3[i], ad[i], d, lat, e, wc, ex[i]);
      end
    end
  endtask

  task automatic test_rmw;
    int lat, wc; logic [31:0] d, wa, wdt; logic e, rd;
    run_req(1'b1, 3'b000, 32'h21, 32'h0000_00AA, lat, d, e, wc, wa, wdt, rd);
    checks++;
    if (wdt !== 32'hDEAD_AAEF || wc !== 2 || wa !== 32'h20 || rd !== 1'b1) begin
      errors++;
      $display("FAIL sb_write: data=%h cyc=%0d addr=%h rd=%b, required deadaaef 2 00000020 1",
               wdt, wc, wa, rd);
    end
    checks++;
    if (lat !== 3 || e !== 1'b0) begin
      errors++;
      $display("FAIL sb_rsp: lat=%0d err=%b, required 3 0", lat, e);
    end
    run_req(1'b1, 3'b001, 32'h22, 32'h0000_1234, lat, d, e, wc, wa, wdt, rd);
    checks++;
    if (wdt !== 32'h1234_AAEF || wc !== 2 || lat !== 3) begin
      errors++;
      $display("FAIL sh_write: data=%h cyc=%0d lat=%0d, required 1234aaef 2 3", wdt, wc, lat);
    end
  endtask

  task automatic test_errors;
    logic        we [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3 [4] = '{3'b010, 3'b111, 3'b011, 3'b001};
    logic [31:0] ad [4] = '{32'h22, 32'h10, 32'h20, 32'h21};
    int lat, wc; logic [31:0] d, wa, wdt; logic e, rd;
    for (int i = 0; i < 4; i++) begin
      run_req(we[i], f3[i], ad[i], 32'hFFFF_FFFF, lat, d, e, wc, wa, wdt, rd);
      checks++;
      if (e !== 1'b1 || d !== 32'h0 || lat !== 1 || rd !== 1'b0 || wc !== -1) begin
        errors++;
        $display("FAIL err%0d we=%b f3=%b addr=%h: err=%b data=%h lat=%0d rd=%b wcyc=%0d, required 1 0 1 0 -1",
                 i, we[i], f3[i], ad[i], e, d, lat, rd, wc);
      end
    end
    // memory must be unchanged by the rejected stores
    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, d, e, wc, wa, wdt, rd);
    checks++;
    if (d !== 32'h1234_AAEF) begin
      errors++;
      $display("FAIL err_nowrite: word=%h, required 1234aaef", d);
    end
  endtask

  task automatic test_reset_mid;
    int n; logic wseen, rseen, ready0;
    int lat, wc; logic [31:0] d, wa, wdt; logic e, rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h20; req_wdata = 32'h55;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_r_enb !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_in_rmw: r_enb=%b rsp_valid=%b, required 1 0", mem_r_enb, rsp_valid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    wseen = 1'b0; rseen = 1'b0; ready0 = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) ready0 = req_ready;
      if (mem_w_enb) wseen = 1'b1;
      if (rsp_valid) rseen = 1'b1;
    end
    checks++;
    if (ready0 !== 1'b1 || wseen !== 1'b0 || rseen !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_after: ready=%b wseen=%b rspseen=%b, required 1 0 0", ready0, wseen, rseen);
    end
    run_req(1'b0, 3'b010, 32'h20, 32'h0, lat, d, e, wc, wa, wdt, rd);
    checks++;
    if (d !== 32'h1234_AAEF || lat !== 2 || e !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_next: data=%h lat=%0d err=%b, required 1234aaef 2 0", d, lat, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b000};
    logic [31:0] ad [3] = '{32'h10, 32'h32, 32'h31};
    logic [31:0] ex [3] = '{32'h8877_6655, 32'hFFFF_80F1, 32'h0000_007F};
    int rcyc [3]; logic [31:0] rdat [3];
    int idx, nr, nready, bad; logic acc;
    idx = 0; nr = 0; nready = 0; bad = 0;
    for (int i = 0; i < 3; i++) begin rcyc[i] = -1; rdat[i] = '0; end
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = f3[0]; req_addr = ad[0]; req_wdata = '0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      if (rsp_valid && nr < 3) begin rcyc[nr] = c; rdat[nr] = rsp_data; nr++; end
      if (req_ready && (rsp_valid || mem_r_enb)) bad++;
      if (req_ready && c <= 8) nready++;
      acc = req_ready && (idx < 3);
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin req_funct3 = f3[idx]; req_addr = ad[idx]; end
        else req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checks++;
    if (nr !== 3 || rcyc[0] !== 2 || rcyc[1] !== 5 || rcyc[2] !== 8) begin
      errors++;
      $display("FAIL b2b_timing: pulses=%0d cycles=%0d,%0d,%0d, required 3 2,5,8",
               nr, rcyc[0], rcyc[1], rcyc[2]);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rdat[i] !== ex[i]) begin
        errors++;
        $display("FAIL b2b_data%0d: got %h, required %h", i, rdat[i], ex[i]);
      end
    end
    checks++;
    if (nready !== 3 || bad !== 0) begin
      errors++;
      $display("FAIL b2b_ready: ready_cycles=%0d overlap=%0d, required 3 0", nready, bad);
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    rst = 1'b1;
    test_reset();
    test_sw();
    test_loads();
    test_rmw();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, required completion");
    $fatal(1, "timeout");
  end

endmodule
